// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, ALU and bus select codes,
// sequencer states and condition-code bit positions.
package cpu_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA     = 8'h96;
  localparam logic [7:0] OP_STB     = 8'h97;
  localparam logic [7:0] OP_ADD     = 8'h42;
  localparam logic [7:0] OP_SUB     = 8'h43;
  localparam logic [7:0] OP_AND     = 8'h44;
  localparam logic [7:0] OP_OR      = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_DECA    = 8'h47;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BEQ     = 8'h21;
  localparam logic [7:0] OP_BNE     = 8'h22;
  localparam logic [7:0] OP_BMI     = 8'h23;
  localparam logic [7:0] OP_BCS     = 8'h24;
  localparam logic [7:0] OP_HALT    = 8'hFF;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_INCA = 4'b0100;
  localparam logic [3:0] ALU_DECA = 4'b0101;

  localparam logic [1:0] BUS1_PC = 2'b00;
  localparam logic [1:0] BUS1_A  = 2'b01;
  localparam logic [1:0] BUS1_B  = 2'b10;

  localparam logic [2:0] BUS2_ALU  = 3'b000;
  localparam logic [2:0] BUS2_BUS1 = 3'b001;
  localparam logic [2:0] BUS2_MEM  = 3'b010;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  typedef enum logic [4:0] {
    S_F0, S_F1, S_DEC,
    S_I0, S_I1,
    S_D0, S_D1, S_D2, S_D3, S_ST,
    S_ALU,
    S_B0, S_B1,
    S_HALT
  } state_t;

  function automatic logic [3:0] alu_sel_of(input logic [7:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_INCA: return ALU_INCA;
      OP_DECA: return ALU_DECA;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluation: decides taken/not-taken from opcode and flags.
module branch_eval
  import cpu_pkg::*;
(
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       taken
);

  // No branch looks at overflow; kept visible so the port stays a full CCR.
  logic unused_v;
  assign unused_v = CCR_Result[CCR_V];

  always_comb begin
    taken = 1'b0;
    case (IR)
      OP_BRA:  taken = 1'b1;
      OP_BEQ:  taken = CCR_Result[CCR_Z];
      OP_BNE:  taken = ~CCR_Result[CCR_Z];
      OP_BMI:  taken = CCR_Result[CCR_N];
      OP_BCS:  taken = CCR_Result[CCR_C];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer. Outputs are decoded from the
// state register (plus the latched opcode), so they drop together with reset.
module control_unit
  import cpu_pkg::*;
#(
  parameter state_t RESET_STATE = S_F0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       CCR_Load,
  output logic [3:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [2:0] Bus2_Sel,
  output logic       addr_sel,
  output logic       write,
  output logic       reg_we,
  output logic       reg_wsel,
  output logic [7:0] immediate_value,
  output logic [7:0] address_value,
  output logic       halted
);

  state_t state;
  logic   taken;

  branch_eval u_branch_eval (
    .IR         (IR),
    .CCR_Result (CCR_Result),
    .taken      (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else begin
      case (state)
        S_F0:  state <= S_F1;
        S_F1:  state <= S_DEC;
        S_DEC: begin
          case (IR)
            OP_LDA_IMM, OP_LDB_IMM:                 state <= S_I0;
            OP_LDA_DIR, OP_LDB_DIR, OP_STA, OP_STB: state <= S_D0;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_INCA, OP_DECA:                       state <= S_ALU;
            OP_BRA, OP_BEQ, OP_BNE, OP_BMI, OP_BCS: state <= S_B0;
            OP_HALT:                                state <= S_HALT;
            default:                                state <= S_F0;
          endcase
        end
        S_I0:   state <= S_I1;
        S_I1:   state <= S_F0;
        S_D0:   state <= S_D1;
        // Stores and direct loads share the operand fetch, then split.
        S_D1:   state <= (IR == OP_STA || IR == OP_STB) ? S_ST : S_D2;
        S_D2:   state <= S_D3;
        S_D3:   state <= S_F0;
        S_ST:   state <= S_F0;
        S_ALU:  state <= S_F0;
        S_B0:   state <= S_B1;
        S_B1:   state <= S_F0;
        S_HALT: state <= S_HALT;
        default: state <= S_F0;
      endcase
    end
  end

  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = BUS1_PC;
    Bus2_Sel = BUS2_ALU;
    addr_sel = 1'b0;
    write    = 1'b0;
    reg_we   = 1'b0;
    reg_wsel = 1'b0;
    case (state)
      S_F1: begin
        IR_Load  = 1'b1;
        Bus2_Sel = BUS2_MEM;
        PC_Inc   = 1'b1;
      end
      S_I1: begin
        Bus2_Sel = BUS2_MEM;
        reg_we   = 1'b1;
        reg_wsel = (IR == OP_LDB_IMM);
        PC_Inc   = 1'b1;
      end
      S_D1: begin
        MAR_Load = 1'b1;
        Bus2_Sel = BUS2_MEM;
        PC_Inc   = 1'b1;
      end
      S_D2: addr_sel = 1'b1;
      S_D3: begin
        addr_sel = 1'b1;
        Bus2_Sel = BUS2_MEM;
        reg_we   = 1'b1;
        reg_wsel = (IR == OP_LDB_DIR);
      end
      S_ST: begin
        addr_sel = 1'b1;
        write    = 1'b1;
        Bus1_Sel = (IR == OP_STB) ? BUS1_B : BUS1_A;
      end
      S_ALU: begin
        ALU_Sel  = alu_sel_of(IR);
        Bus2_Sel = BUS2_ALU;
        reg_we   = 1'b1;
        CCR_Load = 1'b1;
      end
      // Taken: datapath adds the offset byte to the operand address in PC.
      S_B1: begin
        if (taken) begin
          PC_Load  = 1'b1;
          Bus2_Sel = BUS2_MEM;
        end else begin
          PC_Inc   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign halted          = (state == S_HALT);
  assign immediate_value = 8'h00;
  assign address_value   = 8'h00;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: control_unit driving a small behavioural datapath and
// synchronous memory, checking per-cycle control words and datapath results.
module tb_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load;
  logic [3:0] ALU_Sel;
  logic [1:0] Bus1_Sel;
  logic [2:0] Bus2_Sel;
  logic       addr_sel, write, reg_we, reg_wsel, halted;
  logic [7:0] immediate_value, address_value;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .CCR_Load(CCR_Load), .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .addr_sel(addr_sel), .write(write), .reg_we(reg_we), .reg_wsel(reg_wsel),
    .immediate_value(immediate_value), .address_value(address_value), .halted(halted)
  );

  // Behavioural datapath and memory around the sequencer.
  logic [7:0] pc, mar, ir_q, ra, rb, mem_q;
  logic [3:0] ccr;
  logic [7:0] mem [256];
  logic       tb_we, ld_en;
  logic [7:0] tb_wa, tb_wd, ld_pc, ld_a, ld_b;
  logic [3:0] ld_ccr;
  logic [7:0] bus1, bus2, addr;
  logic [8:0] alu_w;

  assign IR         = ir_q;
  assign CCR_Result = ccr;
  assign addr       = addr_sel ? mar : pc;
  assign bus1       = (Bus1_Sel == 2'b01) ? ra : (Bus1_Sel == 2'b10) ? rb : pc;
  assign bus2       = (Bus2_Sel == 3'b000) ? alu_w[7:0] :
                      (Bus2_Sel == 3'b001) ? bus1 :
                      (Bus2_Sel == 3'b010) ? mem_q : 8'h00;

  always_comb begin
    alu_w = 9'h000;
    case (ALU_Sel)
      4'd0: alu_w = {1'b0, ra} + {1'b0, rb};
      4'd1: alu_w = {1'b0, ra} - {1'b0, rb};
      4'd2: alu_w = {1'b0, ra & rb};
      4'd3: alu_w = {1'b0, ra | rb};
      4'd4: alu_w = {1'b0, ra} + 9'd1;
      4'd5: alu_w = {1'b0, ra} - 9'd1;
      default: alu_w = 9'h000;
    endcase
  end

  always @(posedge clk) begin
    mem_q <= mem[addr];
    if (tb_we) mem[tb_wa] <= tb_wd;
    else if (write) mem[addr] <= bus1;
    if (ld_en) begin
      pc <= ld_pc; ra <= ld_a; rb <= ld_b; ccr <= ld_ccr; mar <= 8'h00; ir_q <= 8'h00;
    end else begin
      if (IR_Load) ir_q <= bus2;
      if (MAR_Load) mar <= bus2;
      if (PC_Load) pc <= pc + bus2;
      else if (PC_Inc) pc <= pc + 8'h01;
      if (reg_we) begin
        if (reg_wsel) rb <= bus2;
        else ra <= bus2;
      end
      if (CCR_Load) ccr <= {alu_w[7], alu_w[7:0] == 8'h00, 1'b0, alu_w[8]};
    end
  end

  // Control word: {IR_Load,MAR_Load,PC_Load,PC_Inc,CCR_Load,write,reg_we,
  //                reg_wsel,addr_sel,halted,Bus1_Sel,Bus2_Sel,ALU_Sel}
  function automatic logic [18:0] mk(input int irl, marl, pcl, pci, ccrl, wr, we,
                                     ws, as, hl, b1, b2, alu);
    logic [18:0] w;
    w = {irl[0], marl[0], pcl[0], pci[0], ccrl[0], wr[0], we[0], ws[0], as[0], hl[0],
         b1[1:0], b2[2:0], alu[3:0]};
    return w;
  endfunction

  logic [18:0] ctl, IDLE, FETCH1;
  assign ctl = mk(IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, write, reg_we,
                  reg_wsel, addr_sel, halted, Bus1_Sel, Bus2_Sel, ALU_Sel);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic preload(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c);
    ld_pc = p; ld_a = a; ld_b = b; ld_ccr = c; ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; #3; reset = 1'b0; #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", ctl, IDLE);
    end
    checks++;
    if (immediate_value !== 8'h00 || address_value !== 8'h00) begin
      errors++; $display("FAIL reset_ties: got %h/%h want 00/00", immediate_value, address_value);
    end
    tick();
  endtask

  task automatic test_lda_imm();
    logic [18:0] exp [5];
    exp = '{IDLE, FETCH1, IDLE, IDLE, mk(0,0,0,1,0,0,1,0,0,0,0,2,0)};
    reset = 1'b0;
    poke(8'h00, 8'h86); poke(8'h01, 8'h5A);
    preload(8'h00, 8'h00, 8'h00, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL lda_imm_cycle%0d: got %h want %h", c + 1, ctl, exp[c]);
      end
      if (c == 4) begin
        checks++;
        if (bus2 !== 8'h5A) begin
          errors++; $display("FAIL lda_imm_bus2: got %h want 5a", bus2);
        end
      end
      tick();
    end
    checks++;
    if (ra !== 8'h5A || pc !== 8'h02) begin
      errors++; $display("FAIL lda_imm_result: got A=%h PC=%h want A=5a PC=02", ra, pc);
    end
  endtask

  task automatic test_lda_direct();
    logic [18:0] exp [7];
    exp = '{IDLE, FETCH1, IDLE, IDLE, mk(0,1,0,1,0,0,0,0,0,0,0,2,0),
            mk(0,0,0,0,0,0,0,0,1,0,0,0,0), mk(0,0,0,0,0,0,1,0,1,0,0,2,0)};
    reset = 1'b0;
    poke(8'h00, 8'h87); poke(8'h01, 8'h10); poke(8'h10, 8'hC3);
    preload(8'h00, 8'h00, 8'h11, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL lda_dir_cycle%0d: got %h want %h", c + 1, ctl, exp[c]);
      end
      if (c == 6) begin
        checks++;
        if (bus2 !== 8'hC3) begin
          errors++; $display("FAIL lda_dir_bus2: got %h want c3", bus2);
        end
      end
      tick();
    end
    checks++;
    if (mar !== 8'h10 || ra !== 8'hC3 || rb !== 8'h11 || pc !== 8'h02) begin
      errors++;
      $display("FAIL lda_dir_result: got MAR=%h A=%h B=%h PC=%h want 10 c3 11 02", mar, ra, rb, pc);
    end
  endtask

  task automatic test_sta();
    logic [18:0] exp [6];
    exp = '{IDLE, FETCH1, IDLE, IDLE, mk(0,1,0,1,0,0,0,0,0,0,0,2,0),
            mk(0,0,0,0,0,1,0,0,1,0,1,0,0)};
    reset = 1'b0;
    poke(8'h00, 8'h96); poke(8'h01, 8'h20); poke(8'h20, 8'h00);
    preload(8'h00, 8'h77, 8'h00, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL sta_cycle%0d: got %h want %h", c + 1, ctl, exp[c]);
      end
      tick();
    end
    checks++;
    if (mem[8'h20] !== 8'h77 || pc !== 8'h02) begin
      errors++; $display("FAIL sta_result: got mem=%h PC=%h want 77 02", mem[8'h20], pc);
    end
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("FAIL sta_next_fetch: got %h want %h", ctl, IDLE);
    end
  endtask

  task automatic run_branch(input logic [7:0] op, input logic [7:0] off, input logic [3:0] flags,
                            input int tk, input logic [7:0] exp_pc);
    logic [18:0] exp [5];
    exp = '{IDLE, FETCH1, IDLE, IDLE, mk(0,0,tk,1-tk,0,0,0,0,0,0,0,tk*2,0)};
    reset = 1'b0;
    poke(8'h10, op); poke(8'h11, off);
    preload(8'h10, 8'h00, 8'h00, flags);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL branch_%h_cycle%0d: got %h want %h", op, c + 1, ctl, exp[c]);
      end
      tick();
    end
    checks++;
    if (pc !== exp_pc) begin
      errors++; $display("FAIL branch_%h_pc: got %h want %h", op, pc, exp_pc);
    end
  endtask

  task automatic test_branch();
    run_branch(8'h21, 8'h04, 4'b0100, 1, 8'h15);
    run_branch(8'h21, 8'h04, 4'b0000, 0, 8'h12);
    run_branch(8'h20, 8'hFE, 4'b0000, 1, 8'h0F);
    run_branch(8'h22, 8'h04, 4'b0100, 0, 8'h12);
    run_branch(8'h23, 8'h03, 4'b1000, 1, 8'h14);
    run_branch(8'h24, 8'h03, 4'b1110, 0, 8'h12);
    run_branch(8'h24, 8'hF0, 4'b0001, 1, 8'h01);
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp [9];
    exp = '{IDLE, FETCH1, IDLE, mk(0,0,0,0,1,0,1,0,0,0,0,0,1),
            IDLE, FETCH1, IDLE, IDLE, mk(0,0,1,0,0,0,0,0,0,0,0,2,0)};
    reset = 1'b0;
    poke(8'h00, 8'h43); poke(8'h01, 8'h21); poke(8'h02, 8'h04);
    preload(8'h00, 8'h33, 8'h33, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL sub_beq_cycle%0d: got %h want %h", c + 1, ctl, exp[c]);
      end
      tick();
    end
    checks++;
    if (ra !== 8'h00 || ccr !== 4'b0100 || pc !== 8'h06) begin
      errors++; $display("FAIL sub_beq_result: got A=%h CCR=%h PC=%h want 00 4 06", ra, ccr, pc);
    end
  endtask

  task automatic test_nop();
    logic [18:0] exp [5];
    exp = '{IDLE, FETCH1, IDLE, IDLE, FETCH1};
    reset = 1'b0;
    poke(8'h00, 8'h55); poke(8'h01, 8'h55);
    preload(8'h00, 8'h00, 8'h00, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ctl !== exp[c]) begin
        errors++; $display("FAIL nop_cycle%0d: got %h want %h", c + 1, ctl, exp[c]);
      end
      tick();
    end
    checks++;
    if (pc !== 8'h02) begin
      errors++; $display("FAIL nop_pc: got %h want 02", pc);
    end
  endtask

  task automatic test_halt();
    logic [18:0] hw;
    hw = mk(0,0,0,0,0,0,0,0,0,1,0,0,0);
    reset = 1'b0;
    poke(8'h00, 8'hFF);
    preload(8'h00, 8'h00, 8'h00, 4'h0);
    reset = 1'b1;
    tick(); tick(); tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (ctl !== hw) begin
        errors++; $display("FAIL halt_cycle%0d: got %h want %h", c + 1, ctl, hw);
      end
      tick();
    end
    checks++;
    if (pc !== 8'h01) begin
      errors++; $display("FAIL halt_pc: got %h want 01", pc);
    end
  endtask

  task automatic test_reset_abort();
    reset = 1'b0;
    poke(8'h00, 8'h89); poke(8'h01, 8'h10); poke(8'h10, 8'hC3);
    preload(8'h00, 8'h00, 8'h11, 4'h0);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (reg_we !== 1'b1 || reg_wsel !== 1'b1) begin
      errors++; $display("FAIL abort_in_d3: got we=%b wsel=%b want 1 1", reg_we, reg_wsel);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (ctl !== IDLE) begin
      errors++; $display("FAIL abort_outputs: got %h want %h", ctl, IDLE);
    end
    tick();
    checks++;
    if (rb !== 8'h11) begin
      errors++; $display("FAIL abort_no_write: got B=%h want 11", rb);
    end
  endtask

  initial begin
    tb_we = 1'b0; tb_wa = 8'h00; tb_wd = 8'h00;
    ld_en = 1'b0; ld_pc = 8'h00; ld_a = 8'h00; ld_b = 8'h00; ld_ccr = 4'h0;
    IDLE   = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
    FETCH1 = mk(1,0,0,1,0,0,0,0,0,0,0,2,0);
    test_reset();
    test_lda_imm();
    test_lda_direct();
    test_sta();
    test_branch();
    test_back_to_back();
    test_nop();
    test_halt();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
